// File: rtl/npc_lsu.sv
// rtl/npc_lsu.sv - multi-cycle load/store unit bridging EXU requests to a handshaked memory bus
// Aligns store data to byte lanes, extends load data, and reports misalignment, illegal width and bus errors.
module npc_lsu #(
  parameter int XLEN          = 32,
  parameter int ADDR_W        = 32,
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_width,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_wen,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wmask,
  input  logic              bus_rsp_valid,
  input  logic [XLEN-1:0]   bus_rsp_data,
  input  logic              bus_rsp_err
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_next;

  logic              wen_q;
  logic [2:0]        width_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q, rdata_next;
  logic              err_q, err_next;

  logic              accept_err;
  logic [3:0]        size_q;
  logic [OFF_W-1:0]  off;
  logic [NB-1:0]     mask;
  logic [6:0]        pad;
  logic [XLEN-1:0]   shifted, left, load_val;

  function automatic logic [3:0] size_of(input logic [2:0] width);
    return 4'd1 << width[1:0];
  endfunction

  function automatic logic width_bad(input logic [2:0] width);
    return (width == 3'b111) || (XLEN == 32 && (width == 3'b011 || width == 3'b110));
  endfunction

  function automatic logic misaligned(input logic [OFF_W-1:0] low, input logic [2:0] width);
    return |(low & OFF_W'(size_of(width) - 4'd1));
  endfunction

  // Load extraction: move the addressed lanes to bit 0, then shift up and back down to extend.
  always_comb begin
    accept_err = width_bad(req_width) ||
                 (MISALIGN_TRAP && misaligned(req_addr[OFF_W-1:0], req_width));
    size_q  = size_of(width_q);
    off     = misaligned(addr_q[OFF_W-1:0], width_q) ? '0 : addr_q[OFF_W-1:0];
    mask    = NB'((16'd1 << size_q) - 16'd1) << off;
    pad     = 7'(XLEN) - {size_q, 3'b000};
    shifted = bus_rsp_data >> {off, 3'b000};
    left    = shifted << pad;
    if (width_q[2]) begin
      load_val = left >> pad;
    end else begin
      load_val = $signed(left) >>> pad;
    end
  end

  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_rdata     = '0;
    rsp_err       = 1'b0;
    bus_req_valid = 1'b0;
    bus_wen       = 1'b0;
    bus_addr      = '0;
    bus_wdata     = '0;
    bus_wmask     = '0;
    rdata_next    = rdata_q;
    err_next      = err_q;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = accept_err ? DONE : REQ;
          err_next   = accept_err;
          rdata_next = '0;
        end
      end
      REQ: begin
        bus_req_valid = 1'b1;
        bus_wen       = wen_q;
        bus_addr      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        bus_wdata     = wdata_q << {off, 3'b000};
        bus_wmask     = wen_q ? mask : '0;
        if (bus_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (bus_rsp_valid) begin
          state_next = DONE;
          err_next   = bus_rsp_err;
          rdata_next = (wen_q || bus_rsp_err) ? '0 : load_val;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      wen_q   <= 1'b0;
      width_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      rdata_q <= rdata_next;
      err_q   <= err_next;
      if (state == IDLE && req_valid) begin
        wen_q   <= req_wen;
        width_q <= req_width;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_npc_lsu.sv
// tb/tb_npc_lsu.sv - directed bench for npc_lsu: XLEN=32 with misalign trap, XLEN=64 without
module tb_npc_lsu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_bus_cycles = 0;

  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        bus_req_valid, bus_req_ready, bus_wen;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_rsp_valid, bus_rsp_err;
  logic [31:0] bus_rsp_data;

  logic        d_req_valid, d_req_ready, d_req_wen;
  logic [2:0]  d_req_width;
  logic [31:0] d_req_addr;
  logic [63:0] d_req_wdata;
  logic        d_rsp_valid, d_rsp_ready, d_rsp_err;
  logic [63:0] d_rsp_rdata;
  logic        d_bus_req_valid, d_bus_req_ready, d_bus_wen;
  logic [31:0] d_bus_addr;
  logic [63:0] d_bus_wdata;
  logic [7:0]  d_bus_wmask;
  logic        d_bus_rsp_valid, d_bus_rsp_err;
  logic [63:0] d_bus_rsp_data;

  npc_lsu #(.XLEN(32), .ADDR_W(32), .MISALIGN_TRAP(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_width(req_width),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_wen(bus_wen),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data), .bus_rsp_err(bus_rsp_err)
  );

  npc_lsu #(.XLEN(64), .ADDR_W(32), .MISALIGN_TRAP(1'b0)) u_dut64 (
    .clk(clk), .rst(rst),
    .req_valid(d_req_valid), .req_ready(d_req_ready), .req_wen(d_req_wen), .req_width(d_req_width),
    .req_addr(d_req_addr), .req_wdata(d_req_wdata),
    .rsp_valid(d_rsp_valid), .rsp_ready(d_rsp_ready), .rsp_rdata(d_rsp_rdata), .rsp_err(d_rsp_err),
    .bus_req_valid(d_bus_req_valid), .bus_req_ready(d_bus_req_ready), .bus_wen(d_bus_wen),
    .bus_addr(d_bus_addr), .bus_wdata(d_bus_wdata), .bus_wmask(d_bus_wmask),
    .bus_rsp_valid(d_bus_rsp_valid), .bus_rsp_data(d_bus_rsp_data), .bus_rsp_err(d_bus_rsp_err)
  );

  always @(negedge clk) if (bus_req_valid) n_bus_cycles++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic req32(input logic wen, input logic [2:0] width, input logic [31:0] addr,
                       input logic [31:0] wdata);
    @(negedge clk);
    check("req_ready idle", req_ready, 1'b1);
    req_valid = 1'b1; req_wen = wen; req_width = width; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Memory model: optional request stall, response one cycle after the handshake,
  // optional junk responses while the request is still pending.
  task automatic bus32(input logic [31:0] rdata, input logic berr, input int stall, input bit noise,
                       output int lat, output int n_hs, output logic [68:0] fields, output bit unstable);
    int waited = 0;
    bit pending = 0;
    bit seen = 0;
    lat = 1; n_hs = 0; fields = '0; unstable = 0;
    while (!rsp_valid && lat < 40) begin
      if (bus_req_valid) begin
        if (!seen) fields = {bus_wen, bus_addr, bus_wdata, bus_wmask};
        else if (fields !== {bus_wen, bus_addr, bus_wdata, bus_wmask}) unstable = 1;
        seen = 1;
      end
      bus_req_ready = bus_req_valid && (waited >= stall);
      if (bus_req_valid && !bus_req_ready) waited++;
      bus_rsp_valid = pending || (noise && bus_req_valid);
      bus_rsp_data  = pending ? rdata : 32'h5555_5555;
      bus_rsp_err   = pending ? berr : noise;
      pending = bus_req_valid && bus_req_ready;
      if (pending) n_hs++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; bus_rsp_data = '0;
  endtask

  task automatic take_rsp32(input string tag, input logic [31:0] exp_rdata, input logic exp_err,
                            input int hold);
    bit unstable = 0;
    check({tag, " rsp_valid"}, rsp_valid, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== exp_rdata || rsp_err !== exp_err) unstable = 1;
    end
    if (hold > 0) check({tag, " rsp held"}, unstable, 1'b0);
    rsp_ready = 1'b1;
    check({tag, " rdata"}, rsp_rdata, exp_rdata);
    check({tag, " err"}, rsp_err, exp_err);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " rsp_valid drop"}, rsp_valid, 1'b0);
  endtask

  task automatic txn32(input string tag, input logic wen, input logic [2:0] width,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] bus_data,
                       input logic berr, input int exp_lat, input logic [31:0] exp_rdata,
                       input logic exp_err, output logic [68:0] fields);
    int lat, n_hs, bc0;
    bit unstable;
    bc0 = n_bus_cycles;
    req32(wen, width, addr, wdata);
    bus32(bus_data, berr, 0, 1'b0, lat, n_hs, fields, unstable);
    check({tag, " latency"}, lat, exp_lat);
    take_rsp32(tag, exp_rdata, exp_err, 0);
    check({tag, " bus cycles"}, n_bus_cycles - bc0, (exp_lat == 1) ? 0 : 1);
  endtask

  task automatic txn64(input string tag, input logic wen, input logic [2:0] width,
                       input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] bus_data,
                       input logic [63:0] exp_rdata, input logic [31:0] exp_addr,
                       input logic [63:0] exp_wdata, input logic [7:0] exp_mask);
    @(negedge clk);
    check({tag, " req_ready"}, d_req_ready, 1'b1);
    d_req_valid = 1'b1; d_req_wen = wen; d_req_width = width; d_req_addr = addr; d_req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    d_req_valid = 1'b0;
    check({tag, " bus_req_valid"}, d_bus_req_valid, 1'b1);
    check({tag, " bus_addr"}, d_bus_addr, exp_addr);
    check({tag, " bus_wmask"}, d_bus_wmask, exp_mask);
    if (wen) check({tag, " bus_wdata"}, d_bus_wdata, exp_wdata);
    d_bus_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_bus_req_ready = 1'b0; d_bus_rsp_valid = 1'b1; d_bus_rsp_data = bus_data;
    @(posedge clk);
    @(negedge clk);
    d_bus_rsp_valid = 1'b0; d_bus_rsp_data = '0;
    check({tag, " rsp_valid"}, d_rsp_valid, 1'b1);
    check({tag, " rdata"}, d_rsp_rdata, exp_rdata);
    check({tag, " err"}, d_rsp_err, 1'b0);
    d_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [68:0] f;
    int lat, n_hs, extra;
    bit unstable;
    req_valid = 0; req_wen = 0; req_width = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_data = 0; bus_rsp_err = 0;
    d_req_valid = 0; d_req_wen = 0; d_req_width = 0; d_req_addr = 0; d_req_wdata = 0; d_rsp_ready = 0;
    d_bus_req_ready = 0; d_bus_rsp_valid = 0; d_bus_rsp_data = 0; d_bus_rsp_err = 0;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", req_ready, 1'b1);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err", rsp_err, 1'b0);
    check("reset bus_req_valid", bus_req_valid, 1'b0);
    check("reset bus_wen", bus_wen, 1'b0);
    check("reset bus_addr", bus_addr, 32'h0);
    check("reset bus_wdata", bus_wdata, 32'h0);
    check("reset bus_wmask", bus_wmask, 4'h0);
    rst = 1'b1;

    txn32("sw", 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 32'h0, 1'b0, f);
    check("sw bus_wen", f[68], 1'b1);
    check("sw bus_addr", f[67:36], 32'h8000_0004);
    check("sw bus_wdata", f[35:4], 32'hDEAD_BEEF);
    check("sw bus_wmask", f[3:0], 4'b1111);

    txn32("sb", 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 32'h0, 1'b0, 3, 32'h0, 1'b0, f);
    check("sb bus_addr", f[67:36], 32'h8000_0000);
    check("sb bus_wdata", f[35:4], 32'hAB00_0000);
    check("sb bus_wmask", f[3:0], 4'b1000);

    txn32("lb", 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'hAB00_0000, 1'b0, 3, 32'hFFFF_FFAB, 1'b0, f);
    check("lb bus_wen", f[68], 1'b0);
    check("lb bus_wmask", f[3:0], 4'b0000);
    txn32("lbu", 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'hAB00_0000, 1'b0, 3, 32'h0000_00AB, 1'b0, f);

    txn32("sh", 1'b1, 3'b001, 32'h8000_0002, 32'h0000_1234, 32'h0, 1'b0, 3, 32'h0, 1'b0, f);
    check("sh bus_wdata", f[35:4], 32'h1234_0000);
    check("sh bus_wmask", f[3:0], 4'b1100);
    txn32("lh", 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_7F00, 1'b0, 3, 32'hFFFF_8001, 1'b0, f);
    txn32("lhu", 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h8001_7F00, 1'b0, 3, 32'h0000_8001, 1'b0, f);

    txn32("lh misaligned", 1'b0, 3'b001, 32'h8000_0001, 32'h0, 32'hFFFF_FFFF, 1'b0, 1, 32'h0, 1'b1, f);
    txn32("sw misaligned", 1'b1, 3'b010, 32'h8000_0006, 32'h1111_2222, 32'h0, 1'b0, 1, 32'h0, 1'b1, f);
    txn32("ld xlen32", 1'b0, 3'b011, 32'h8000_0008, 32'h0, 32'hFFFF_FFFF, 1'b0, 1, 32'h0, 1'b1, f);
    txn32("lwu xlen32", 1'b0, 3'b110, 32'h8000_0008, 32'h0, 32'hFFFF_FFFF, 1'b0, 1, 32'h0, 1'b1, f);
    txn32("lw buserr", 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h1234_5678, 1'b1, 3, 32'h0, 1'b1, f);

    req32(1'b0, 3'b010, 32'h8000_0010, 32'h0);
    bus32(32'h1234_5678, 1'b0, 5, 1'b1, lat, n_hs, f, unstable);
    check("stall latency", lat, 8);
    check("stall handshakes", n_hs, 1);
    check("stall bus stable", unstable, 1'b0);
    check("stall bus_addr", f[67:36], 32'h8000_0010);
    take_rsp32("stall", 32'h1234_5678, 1'b0, 3);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || bus_req_valid) extra++;
    end
    check("stall single txn", extra, 0);

    req32(1'b0, 3'b010, 32'h8000_0020, 32'h0);
    bus_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_req_ready = 1'b0;
    check("wait bus_req_valid", bus_req_valid, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_data = 32'hCAFE_F00D; bus_rsp_err = 1'b1;
    check("rst-in-wait req_ready", req_ready, 1'b1);
    check("rst-in-wait rsp_valid", rsp_valid, 1'b0);
    check("rst-in-wait rsp_rdata", rsp_rdata, 32'h0);
    check("rst-in-wait rsp_err", rsp_err, 1'b0);
    check("rst-in-wait bus_req_valid", bus_req_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; bus_rsp_data = 32'h0;
    check("late rsp ignored", rsp_valid, 1'b0);
    check("late rsp req_ready", req_ready, 1'b1);
    txn32("lw after reset", 1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'hCAFE_F00D, 1'b0, 3,
          32'hCAFE_F00D, 1'b0, f);

    txn64("x64 lwu", 1'b0, 3'b110, 32'h4, 64'h0, 64'h8000_0000_0000_0000,
          64'h0000_0000_8000_0000, 32'h0, 64'h0, 8'h00);
    txn64("x64 lw", 1'b0, 3'b010, 32'h4, 64'h0, 64'h8000_0000_0000_0000,
          64'hFFFF_FFFF_8000_0000, 32'h0, 64'h0, 8'h00);
    txn64("x64 ld", 1'b0, 3'b011, 32'h8, 64'h0, 64'h0123_4567_89AB_CDEF,
          64'h0123_4567_89AB_CDEF, 32'h8, 64'h0, 8'h00);
    txn64("x64 sw", 1'b1, 3'b010, 32'hC, 64'hDEAD_BEEF, 64'h0,
          64'h0, 32'h8, 64'hDEAD_BEEF_0000_0000, 8'hF0);
    txn64("x64 sh notrap", 1'b1, 3'b001, 32'h9, 64'hBEEF, 64'h0,
          64'h0, 32'h8, 64'h0000_0000_0000_BEEF, 8'h03);
    txn64("x64 lh notrap", 1'b0, 3'b001, 32'hB, 64'h0, 64'h1111_2222_3333_FF80,
          64'hFFFF_FFFF_FFFF_FF80, 32'h8, 64'h0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/npc_lsu.md
Name: npc_lsu

Overview:
- Multi-cycle load/store unit for the next-generation NPC core. It replaces the combinational DPI pmem_read/pmem_write path with a handshaked memory-bus master.
- Sits between EXU (request side) and WBU (response side).
- Parametrised over XLEN (RV32/RV64) and byte-lane width.
- Adds three things the current path lacks: byte-lane alignment, load sign/zero extension, and misalignment and bus-error reporting.

Parameters:
- XLEN, 32, data path width; legal values 32 or 64.
- ADDR_W, 32, address width.
- MISALIGN_TRAP, 1: 1 = misaligned access returns err without bus traffic; 0 = address low bits forced to zero and the access is issued.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  1  EXU request valid.
- req_ready  out  1  LSU can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_width  in  3  funct3 encoding: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  result valid to WBU.
- rsp_ready  in  1  WBU accepts result.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned access, illegal width, or bus error.
- bus_req_valid  out  1  memory request valid.
- bus_req_ready  in  1  memory accepts request.
- bus_wen  out  1  store strobe.
- bus_addr  out  ADDR_W  req_addr with the low log2(XLEN/8) bits cleared.
- bus_wdata  out  XLEN  store data shifted to its byte lanes.
- bus_wmask  out  XLEN/8  byte-enable mask.
- bus_rsp_valid  in  1  memory response (load data or store ack).
- bus_rsp_data  in  XLEN  full-word read data.
- bus_rsp_err  in  1  memory error.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Bus outputs: bus_req_valid=0; bus_wen, bus_addr, bus_wdata and bus_wmask all 0.
  - Reset has priority over every other event. A transaction in flight is abandoned.
- A bus_rsp_valid that arrives in IDLE or REQ is ignored. This covers stale responses after reset.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: req_ready=1. Request accepted on req_valid & req_ready. All request fields are latched in the same cycle.
  - Misaligned (MISALIGN_TRAP=1) or illegal width -> DONE with err=1 and rdata=0; no bus access.
  - Otherwise -> REQ.
- Alignment rule: the address is aligned if addr mod size == 0, with size = 1, 2, 4 or 8 bytes.
- REQ: bus_req_valid=1 and bus fields stable. On bus_req_ready -> WAIT.
  - If bus_rsp_valid is also high in that cycle, the response is ignored; the response must come after the request handshake.
  - Bus fields:
    - off = addr[log2(XLEN/8)-1:0].
    - bus_wmask = ((1<<size)-1) << off.
    - bus_wdata = req_wdata << (8*off).
    - Loads drive bus_wmask=0.
- WAIT: on bus_rsp_valid -> DONE.
  - Loads: rdata = (bus_rsp_data >> 8*off), truncated to size. Sign-extended for B/H/W; zero-extended for BU/HU/WU. D is passed through.
  - Stores: rdata = 0.
  - err = bus_rsp_err. When err=1, rdata = 0.
- DONE: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready -> IDLE.
  - req_ready=0 in REQ, WAIT and DONE; there is no back-to-back bypass. A new request is accepted the cycle after the DONE handshake.
- Latency: accept -> rsp_valid is a minimum of 3 cycles (zero-wait bus), and exactly 1 cycle on the error shortcut.
- XLEN=32 with width 011 or 110 counts as an illegal width -> err.
- MISALIGN_TRAP=0: off is forced to 0, i.e. the access is treated as aligned at the truncated address.

Test Plan:
- Aligned SW, XLEN=32, addr=0x80000004, wdata=0xDEADBEEF, zero-wait bus -> bus_wmask=4'b1111, bus_addr=0x80000004, rsp_valid 3 cycles after accept, rsp_err=0.
- SB addr=0x80000003, wdata=0x000000AB -> bus_wmask=4'b1000, bus_wdata=0xAB000000; then LB at the same address with bus_rsp_data=0xAB000000 -> rsp_rdata=0xFFFFFFAB; LBU -> 0x000000AB.
- LH addr=0x80000001 with MISALIGN_TRAP=1 -> no bus_req_valid, rsp_valid the next cycle, rsp_err=1, rsp_rdata=0.
- LW with bus_req_ready held low for 5 cycles and rsp_ready held low for 3 cycles -> bus fields and rsp fields are stable throughout, and exactly one transaction completes.
- XLEN=64: LWU addr=0x4, bus_rsp_data=0x80000000_00000000 -> rsp_rdata=0x00000000_80000000; LW -> 0xFFFFFFFF_80000000; LD with XLEN=32 -> rsp_err=1.
- rst=0 asserted in WAIT, followed by a late bus_rsp_valid -> all outputs return to reset values, the late response is ignored, and a fresh LW completes normally.
